// File: rtl/bk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bk_pkg
//  Description : Shared types and constants for the backup-RAM save/load
//                sequencer (bk_seq) and its watchdog.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Contents:
//    bk_state_t      sequencer state: IDLE, REQ (request out, waiting for
//                    ack rise), XFER (ack high, waiting for ack fall)
//    c_sector_bytes  bytes per SD sector moved per handshake
// ============================================================================
package bk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } bk_state_t;

  localparam int unsigned c_sector_bytes = 512;

endpackage
`default_nettype wire

// File: rtl/bk_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : bk_watchdog
//  Description : Free-running progress watchdog. Counts while run is high,
//                restarts on clr, and flags expiry once the counter has
//                reached all-ones (2**TMO_BITS cycles without a clear).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk_sys  in   system clock
//    RESET_n  in   asynchronous active-low reset
//    clr      in   restart the count (handshake progress)
//    run      in   count enable (transfer in progress)
//    expired  out  timeout reached this cycle
// ============================================================================
module bk_watchdog #(
  parameter int TMO_BITS = 24
) (
  input  logic clk_sys,
  input  logic RESET_n,
  input  logic clr,
  input  logic run,
  output logic expired
);

  logic [TMO_BITS-1:0] r_cnt;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + TMO_BITS'(1);
    end
  end

  // Progress seen in the same cycle beats expiry.
  assign expired = run & ~clr & (&r_cnt);

endmodule
`default_nettype wire

// File: rtl/bk_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bk_seq
//  Description : Backup-RAM save/load sequencer. Moves one slot of
//                2**SECT_BITS sectors between cartridge backup RAM and the
//                hps_io SD sector interface, tracks a dirty flag with
//                autosave, and aborts on image loss or handshake timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports:
//    clk_sys       in   system clock
//    RESET_n       in   asynchronous active-low reset
//    bk_ena        in   writable save image mounted
//    load_req      in   load request level (edge detected)
//    save_req      in   save request level (edge detected)
//    autosave_req  in   autosave pulse, acts only when dirty
//    slot          in   slot select, sampled at start
//    dirty_set     in   backup-RAM write pulse
//    sd_lba        out  sector address {slot, sector}, zero-extended
//    sd_rd, sd_wr  out  sector read / write request
//    sd_ack        in   sector transfer acknowledge
//    bk_busy       out  transfer in progress
//    bk_loading    out  load in progress (holds the core in reset)
//    bk_dirty      out  backup RAM modified since last save/load
//    bk_done       out  one-cycle pulse on successful completion
//    bk_err        out  one-cycle pulse on abort
// ============================================================================
module bk_seq
  import bk_pkg::*;
#(
  parameter int SECT_BITS = 6,
  parameter int SLOT_BITS = 2,
  parameter int LBA_W     = 32,
  parameter int TMO_BITS  = 24
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 bk_ena,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic                 autosave_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 dirty_set,
  output logic [LBA_W-1:0]     sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  input  logic                 sd_ack,
  output logic                 bk_busy,
  output logic                 bk_loading,
  output logic                 bk_dirty,
  output logic                 bk_done,
  output logic                 bk_err
);

  bk_state_t            r_state, w_state_nx;
  logic [SECT_BITS-1:0] r_sector, w_sector_nx;
  logic [SLOT_BITS-1:0] r_slot, w_slot_nx;
  logic r_rd, w_rd_nx, r_wr, w_wr_nx;
  logic r_busy, w_busy_nx, r_loading, w_loading_nx;
  logic r_dirty, w_dirty_nx, r_done, w_done_nx, r_err, w_err_nx;
  logic r_load_q, r_save_q, r_ack_q;

  logic w_load_edge, w_save_edge, w_auto, w_ack_rise, w_ack_fall;
  logic w_start, w_abort, w_dirty_clr, w_dirty_abort, w_wdg_expired;

  assign w_load_edge = ~r_load_q & load_req & bk_ena;
  assign w_save_edge = ~r_save_q & save_req & bk_ena;
  // Autosave also needs a mounted image; otherwise it would abort at once.
  assign w_auto      = autosave_req & r_dirty & bk_ena;
  assign w_ack_rise  =  sd_ack & ~r_ack_q;
  assign w_ack_fall  = ~sd_ack &  r_ack_q;
  assign w_abort     = (r_state != IDLE) & (~bk_ena | w_wdg_expired);

  bk_watchdog #(
    .TMO_BITS (TMO_BITS)
  ) u_wdg (
    .clk_sys (clk_sys),
    .RESET_n (RESET_n),
    .clr     (w_start | w_ack_rise | w_ack_fall),
    .run     (r_state != IDLE),
    .expired (w_wdg_expired)
  );

  always_comb begin
    w_state_nx    = r_state;
    w_sector_nx   = r_sector;
    w_slot_nx     = r_slot;
    w_rd_nx       = r_rd;
    w_wr_nx       = r_wr;
    w_busy_nx     = r_busy;
    w_loading_nx  = r_loading;
    w_done_nx     = 1'b0;
    w_err_nx      = 1'b0;
    w_start       = 1'b0;
    w_dirty_clr   = 1'b0;
    w_dirty_abort = 1'b0;

    case (r_state)
      IDLE: begin
        // Load beats save beats autosave.
        if (w_load_edge | w_save_edge | w_auto) begin
          w_start      = 1'b1;
          w_sector_nx  = '0;
          w_slot_nx    = slot;
          w_rd_nx      = w_load_edge;
          w_wr_nx      = ~w_load_edge;
          w_busy_nx    = 1'b1;
          w_loading_nx = w_load_edge;
          w_dirty_clr  = ~w_load_edge;
          w_state_nx   = REQ;
        end
      end
      REQ: begin
        if (w_ack_rise) begin
          w_rd_nx    = 1'b0;
          w_wr_nx    = 1'b0;
          w_state_nx = XFER;
        end
      end
      XFER: begin
        if (w_ack_fall) begin
          // Sector field wraps to zero on the last sector; slot is untouched.
          w_sector_nx = r_sector + SECT_BITS'(1);
          if (&r_sector) begin
            w_busy_nx    = 1'b0;
            w_loading_nx = 1'b0;
            w_done_nx    = 1'b1;
            w_dirty_clr  = r_loading;
            w_state_nx   = IDLE;
          end else begin
            w_rd_nx    = r_loading;
            w_wr_nx    = ~r_loading;
            w_state_nx = REQ;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase

    if (w_abort) begin
      w_rd_nx       = 1'b0;
      w_wr_nx       = 1'b0;
      w_busy_nx     = 1'b0;
      w_loading_nx  = 1'b0;
      w_done_nx     = 1'b0;
      w_err_nx      = 1'b1;
      w_dirty_clr   = 1'b0;
      // A partly written image no longer matches RAM.
      w_dirty_abort = ~r_loading;
      w_state_nx    = IDLE;
    end
  end

  // A CPU write in the same cycle as a clear keeps the flag set.
  assign w_dirty_nx = dirty_set | w_dirty_abort | (r_dirty & ~w_dirty_clr);

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state   <= IDLE;
      r_sector  <= '0;
      r_slot    <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_loading <= 1'b0;
      r_dirty   <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_load_q  <= 1'b0;
      r_save_q  <= 1'b0;
      r_ack_q   <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sector  <= w_sector_nx;
      r_slot    <= w_slot_nx;
      r_rd      <= w_rd_nx;
      r_wr      <= w_wr_nx;
      r_busy    <= w_busy_nx;
      r_loading <= w_loading_nx;
      r_dirty   <= w_dirty_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_load_q  <= load_req;
      r_save_q  <= save_req;
      r_ack_q   <= sd_ack;
    end
  end

  assign sd_lba     = LBA_W'({r_slot, r_sector});
  assign sd_rd      = r_rd;
  assign sd_wr      = r_wr;
  assign bk_busy    = r_busy;
  assign bk_loading = r_loading;
  assign bk_dirty   = r_dirty;
  assign bk_done    = r_done;
  assign bk_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bk_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bk_seq
//  Description : Self-checking bench for bk_seq. A randomized SD host answers
//                sector requests; transfers are judged against the expected
//                slot/sector address list and a transaction-level dirty flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bk_seq;

  localparam int SECTS = 64;

  logic        clk_sys = 1'b0;
  logic        RESET_n = 1'b0;
  logic        bk_ena = 1'b0, load_req = 1'b0, save_req = 1'b0;
  logic        autosave_req = 1'b0, dirty_set = 1'b0, sd_ack = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_busy, bk_loading, bk_dirty, bk_done, bk_err;

  // Second instance with a short watchdog; its host never acknowledges.
  logic        t_save_req = 1'b0, t_zero = 1'b0;
  logic [1:0]  t_slot = 2'd1;
  logic [31:0] t_lba;
  logic        t_rd, t_wr, t_busy, t_loading, t_dirty, t_done, t_err;

  always #5 clk_sys = ~clk_sys;

  bk_seq dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .bk_ena(bk_ena),
    .load_req(load_req), .save_req(save_req), .autosave_req(autosave_req),
    .slot(slot), .dirty_set(dirty_set), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .bk_busy(bk_busy), .bk_loading(bk_loading),
    .bk_dirty(bk_dirty), .bk_done(bk_done), .bk_err(bk_err)
  );

  bk_seq #(.TMO_BITS(4)) dut_t (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .bk_ena(bk_ena),
    .load_req(t_zero), .save_req(t_save_req), .autosave_req(t_zero),
    .slot(t_slot), .dirty_set(t_zero), .sd_lba(t_lba), .sd_rd(t_rd),
    .sd_wr(t_wr), .sd_ack(t_zero), .bk_busy(t_busy), .bk_loading(t_loading),
    .bk_dirty(t_dirty), .bk_done(t_done), .bk_err(t_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit exp_dirty = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SD host model: records every sector request ------------
  int unsigned rec_lba[$];
  logic [1:0]  rec_kind[$];
  int unsigned rec_end[$];
  bit          rec_drop[$];

  initial begin : host
    bit drop;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !sd_ack) begin
        rec_lba.push_back(sd_lba);
        rec_kind.push_back({sd_rd, sd_wr});
        repeat ($urandom_range(0, 3)) @(negedge clk_sys);
        sd_ack = 1'b1;
        @(negedge clk_sys);
        drop = !(sd_rd || sd_wr);
        repeat ($urandom_range(0, 4)) @(negedge clk_sys);
        rec_end.push_back(sd_lba);
        rec_drop.push_back(drop);
        sd_ack = 1'b0;
      end
    end
  end

  // ---------------- Pulse / level monitor ----------------------------------
  int n_done = 0, n_err = 0, n_busy = 0, n_load_hi = 0;
  always @(negedge clk_sys) begin
    if (bk_done)    n_done    <= n_done + 1;
    if (bk_err)     n_err     <= n_err + 1;
    if (bk_busy)    n_busy    <= n_busy + 1;
    if (bk_loading) n_load_hi <= n_load_hi + 1;
  end

  int b_rec, b_end, b_done, b_err, b_busy, b_load;

  task automatic snap();
    b_rec = rec_lba.size(); b_end = rec_end.size();
    b_done = n_done; b_err = n_err; b_busy = n_busy; b_load = n_load_hi;
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    while (bk_busy && i < limit) begin @(negedge clk_sys); i++; end
    check("busy_bound", 64'(bk_busy), 64'(0));
    @(negedge clk_sys);
  endtask

  task automatic wait_host();
    int i = 0;
    while (sd_ack && i < 50) begin @(negedge clk_sys); i++; end
    repeat (2) @(negedge clk_sys);
  endtask

  // Whole-transfer judgement: address sequence, direction, handshakes, pulses.
  task automatic check_xfer(input bit is_load, input int s);
    int n, bad;
    logic [1:0] kind;
    kind = is_load ? 2'b10 : 2'b01;
    n = rec_lba.size() - b_rec;
    bad = 0;
    check("sector_count", 64'(n), 64'(SECTS));
    for (int i = 0; i < n; i++) begin
      if (rec_lba[b_rec+i] != 32'(s * SECTS + i)) bad++;
      if (rec_kind[b_rec+i] != kind) bad++;
    end
    for (int i = 0; i < rec_end.size() - b_end; i++) begin
      if (rec_end[b_end+i] != 32'(s * SECTS + i)) bad++;
      if (!rec_drop[b_end+i]) bad++;
    end
    check("lba_sequence", 64'(bad), 64'(0));
    check("done_pulses", 64'(n_done - b_done), 64'(1));
    check("err_pulses", 64'(n_err - b_err), 64'(0));
    check("loading_cycles", 64'(n_load_hi - b_load), is_load ? 64'(n_busy - b_busy) : 64'(0));
  endtask

  task automatic run_xfer(input bit is_load, input int s, input bit mid_dirty);
    @(negedge clk_sys);
    snap();
    slot = 2'(s);
    if (is_load) load_req = 1'b1; else save_req = 1'b1;
    @(negedge clk_sys);
    check("start_flags", 64'({bk_busy, bk_loading, sd_rd, sd_wr}),
          64'({1'b1, is_load, is_load, ~is_load}));
    check("start_lba", 64'(sd_lba), 64'(s * SECTS));
    if (!is_load) exp_dirty = 1'b0;
    if (mid_dirty) begin
      repeat (20) @(negedge clk_sys);
      dirty_set = 1'b1;
      @(negedge clk_sys);
      dirty_set = 1'b0;
      exp_dirty = 1'b1;
    end
    wait_idle(SECTS * 20);
    if (is_load) exp_dirty = 1'b0;
    check("dirty_end", 64'(bk_dirty), 64'(exp_dirty));
    check_xfer(is_load, s);
    load_req = 1'b0;
    save_req = 1'b0;
  endtask

  initial begin : main
    int cnt, wcnt;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", 64'({sd_lba, sd_rd, sd_wr, bk_busy, bk_loading, bk_dirty, bk_done, bk_err}), 64'(0));
    check("reset_outputs_t", 64'({t_lba, t_rd, t_wr, t_busy, t_loading, t_dirty, t_done, t_err}), 64'(0));
    RESET_n = 1'b1;
    bk_ena  = 1'b1;
    @(negedge clk_sys);
    dirty_set = 1'b1;
    @(negedge clk_sys);
    dirty_set = 1'b0;
    exp_dirty = 1'b1;
    check("dirty_set", 64'(bk_dirty), 64'(1));

    // Plain save to slot 2, then load from slot 0 with RAM dirty beforehand.
    run_xfer(1'b0, 2, 1'b0);
    dirty_set = 1'b1; @(negedge clk_sys); dirty_set = 1'b0;
    exp_dirty = 1'b1;
    run_xfer(1'b1, 0, 1'b0);

    // Randomized transfers.
    for (int k = 0; k < 3; k++)
      run_xfer(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));

    // Load and save edges together: load only; a later save edge is dropped.
    @(negedge clk_sys);
    snap();
    slot = 2'd1;
    load_req = 1'b1; save_req = 1'b1;
    @(negedge clk_sys);
    check("both_edges", 64'({sd_rd, sd_wr, bk_loading}), 64'(3'b101));
    repeat (30) @(negedge clk_sys);
    save_req = 1'b0;
    @(negedge clk_sys);
    save_req = 1'b1;
    @(negedge clk_sys);
    check("mid_save_ignored", 64'({sd_wr, bk_loading}), 64'(2'b01));
    wait_idle(SECTS * 20);
    exp_dirty = 1'b0;
    check("both_dirty", 64'(bk_dirty), 64'(exp_dirty));
    check_xfer(1'b1, 1);
    load_req = 1'b0; save_req = 1'b0;

    // Dirty during save survives completion, then autosave saves again.
    run_xfer(1'b0, 3, 1'b1);
    @(negedge clk_sys);
    snap();
    autosave_req = 1'b1;
    @(negedge clk_sys);
    autosave_req = 1'b0;
    check("autosave_start", 64'({bk_busy, bk_loading, sd_rd, sd_wr, bk_dirty}), 64'(5'b10010));
    exp_dirty = 1'b0;
    wait_idle(SECTS * 20);
    check_xfer(1'b0, 3);
    @(negedge clk_sys);
    snap();
    autosave_req = 1'b1;
    @(negedge clk_sys);
    autosave_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("autosave_clean", 64'({bk_busy, sd_wr}), 64'(0));
    check("autosave_clean_reqs", 64'(rec_lba.size() - b_rec), 64'(0));

    // Image removed during sector 10 of a save.
    @(negedge clk_sys);
    snap();
    slot = 2'd1;
    save_req = 1'b1;
    exp_dirty = 1'b0;
    cnt = 0;
    while ((rec_lba.size() - b_rec) < 11 && cnt < 2000) begin @(negedge clk_sys); cnt++; end
    bk_ena = 1'b0;
    @(negedge clk_sys);
    exp_dirty = 1'b1;
    check("ena_abort", 64'({bk_err, bk_busy, bk_loading, sd_rd, sd_wr, bk_dirty}), 64'(6'b100001));
    @(negedge clk_sys);
    check("ena_err_width", 64'(bk_err), 64'(0));
    check("ena_no_done", 64'(n_done - b_done), 64'(0));
    wait_host();
    save_req = 1'b0;
    bk_ena = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Asynchronous reset in XFER of a load.
    snap();
    slot = 2'd0;
    load_req = 1'b1;
    cnt = 0;
    @(negedge clk_sys);
    while (!(sd_ack && !sd_rd && bk_busy && (rec_end.size() - b_end) >= 2) && cnt < 2000) begin
      @(negedge clk_sys); cnt++;
    end
    #2 RESET_n = 1'b0;
    #1 check("async_reset", 64'({sd_lba, sd_rd, sd_wr, bk_busy, bk_loading, bk_dirty, bk_done, bk_err}), 64'(0));
    load_req = 1'b0;
    exp_dirty = 1'b0;
    repeat (2) @(negedge clk_sys);
    RESET_n = 1'b1;
    wait_host();
    repeat (3) @(negedge clk_sys);
    check("no_restart", 64'({bk_busy, sd_rd, sd_wr}), 64'(0));
    check("no_err_on_reset", 64'(n_err - b_err), 64'(0));
    run_xfer(1'b1, 0, 1'b0);

    // Watchdog: short-timeout instance, ack never rises.
    @(negedge clk_sys);
    t_save_req = 1'b1;
    @(negedge clk_sys);
    cnt = 0; wcnt = 0;
    while (t_busy && cnt < 100) begin
      cnt++;
      if (t_wr) wcnt++;
      @(negedge clk_sys);
    end
    check("tmo_cycles", 64'(cnt), 64'(16));
    check("tmo_wr_cycles", 64'(wcnt), 64'(16));
    check("tmo_abort", 64'({t_err, t_busy, t_rd, t_wr, t_loading, t_dirty}), 64'(6'b100001));
    @(negedge clk_sys);
    check("tmo_err_width", 64'(t_err), 64'(0));
    t_save_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
